// File: rtl/rc4_prga_decrypt_if.sv
// Bus between the RC4 PRGA/decrypt engine and its S memory, ciphertext ROM,
// plaintext RAM and start/status flags.
interface rc4_prga_decrypt_if #(
    parameter int MSG_AW = 5
);
    logic              flag_start;
    logic [7:0]        s_mem_address;
    logic [7:0]        s_mem_data;
    logic              s_mem_wren;
    logic [7:0]        s_mem_q;
    logic [MSG_AW-1:0] enc_rom_address;
    logic [7:0]        enc_rom_q;
    logic [MSG_AW-1:0] dec_ram_address;
    logic [7:0]        dec_ram_data;
    logic              dec_ram_wren;
    logic              flag_busy;
    logic              flag_done;

    modport slave (
        input  flag_start, s_mem_q, enc_rom_q,
        output s_mem_address, s_mem_data, s_mem_wren,
               enc_rom_address, dec_ram_address, dec_ram_data, dec_ram_wren,
               flag_busy, flag_done
    );

    modport master (
        output flag_start, s_mem_q, enc_rom_q,
        input  s_mem_address, s_mem_data, s_mem_wren,
               enc_rom_address, dec_ram_address, dec_ram_data, dec_ram_wren,
               flag_busy, flag_done
    );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator: walks the S array left by the KSA, swaps S[i]/S[j]
// and XORs each ciphertext byte with S[S[i]+S[j]] into the plaintext RAM.
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              inclk,
    input  logic              reset,
    rc4_prga_decrypt_if.slave bus
);
    localparam logic [4:0] ST_IDLE      = 5'd0;
    localparam logic [4:0] ST_INIT      = 5'd1;
    localparam logic [4:0] ST_K_CHECK   = 5'd2;
    localparam logic [4:0] ST_I_INC     = 5'd3;
    localparam logic [4:0] ST_SI_ADDR   = 5'd4;
    localparam logic [4:0] ST_SI_WAIT   = 5'd5;
    localparam logic [4:0] ST_SI_CAP    = 5'd6;
    localparam logic [4:0] ST_J_CALC    = 5'd7;
    localparam logic [4:0] ST_SJ_ADDR   = 5'd8;
    localparam logic [4:0] ST_SJ_WAIT   = 5'd9;
    localparam logic [4:0] ST_SJ_CAP    = 5'd10;
    localparam logic [4:0] ST_SWAP_I    = 5'd11;
    localparam logic [4:0] ST_SWAP_I_WR = 5'd12;
    localparam logic [4:0] ST_SWAP_J    = 5'd13;
    localparam logic [4:0] ST_SWAP_J_WR = 5'd14;
    localparam logic [4:0] ST_F_ADDR    = 5'd15;
    localparam logic [4:0] ST_F_WAIT    = 5'd16;
    localparam logic [4:0] ST_F_CAP     = 5'd17;
    localparam logic [4:0] ST_DEC_WR    = 5'd18;
    localparam logic [4:0] ST_K_INC     = 5'd19;
    localparam logic [4:0] ST_DONE      = 5'd20;

    localparam logic [MSG_AW:0] K_LAST = (MSG_AW+1)'(MSG_LEN);
    localparam logic [MSG_AW:0] K_ONE  = (MSG_AW+1)'(1);

    logic [4:0]        state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [MSG_AW:0]   k_q, k_d;
    logic [7:0]        s_addr_q, s_addr_d, s_data_q, s_data_d;
    logic [MSG_AW-1:0] enc_addr_q, enc_addr_d, dec_addr_q, dec_addr_d;
    logic [7:0]        dec_data_q, dec_data_d;

    // Next-state and datapath update for the one-step-per-cycle sequencer.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        k_d        = k_q;
        s_addr_d   = s_addr_q;
        s_data_d   = s_data_q;
        enc_addr_d = enc_addr_q;
        dec_addr_d = dec_addr_q;
        dec_data_d = dec_data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.flag_start) state_d = ST_INIT;
                else                state_d = ST_IDLE;
            end
            ST_INIT: begin
                i_d     = 8'd0;
                j_d     = 8'd0;
                k_d     = '0;
                state_d = ST_K_CHECK;
            end
            ST_K_CHECK: begin
                if (k_q == K_LAST) state_d = ST_DONE;
                else               state_d = ST_I_INC;
            end
            ST_I_INC:   begin i_d = i_q + 8'd1;        state_d = ST_SI_ADDR; end
            ST_SI_ADDR: begin s_addr_d = i_q;          state_d = ST_SI_WAIT; end
            ST_SI_WAIT: begin                          state_d = ST_SI_CAP;  end
            ST_SI_CAP:  begin si_d = bus.s_mem_q;      state_d = ST_J_CALC;  end
            ST_J_CALC:  begin j_d = j_q + si_q;        state_d = ST_SJ_ADDR; end
            ST_SJ_ADDR: begin s_addr_d = j_q;          state_d = ST_SJ_WAIT; end
            ST_SJ_WAIT: begin                          state_d = ST_SJ_CAP;  end
            ST_SJ_CAP:  begin sj_d = bus.s_mem_q;      state_d = ST_SWAP_I;  end
            // When i==j both writes carry the same byte, so the order is harmless.
            ST_SWAP_I: begin
                s_addr_d = i_q;
                s_data_d = sj_q;
                state_d  = ST_SWAP_I_WR;
            end
            ST_SWAP_I_WR: state_d = ST_SWAP_J;
            ST_SWAP_J: begin
                s_addr_d = j_q;
                s_data_d = si_q;
                state_d  = ST_SWAP_J_WR;
            end
            ST_SWAP_J_WR: state_d = ST_F_ADDR;
            ST_F_ADDR: begin
                s_addr_d   = si_q + sj_q;
                enc_addr_d = k_q[MSG_AW-1:0];
                state_d    = ST_F_WAIT;
            end
            ST_F_WAIT: state_d = ST_F_CAP;
            ST_F_CAP: begin
                dec_addr_d = k_q[MSG_AW-1:0];
                dec_data_d = bus.s_mem_q ^ bus.enc_rom_q;
                state_d    = ST_DEC_WR;
            end
            ST_DEC_WR: state_d = ST_K_INC;
            ST_K_INC: begin
                k_d     = k_q + K_ONE;
                state_d = ST_K_CHECK;
            end
            // Wait for start to drop so a held start cannot retrigger.
            ST_DONE: begin
                if (bus.flag_start) state_d = ST_DONE;
                else                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            k_q        <= '0;
            s_addr_q   <= 8'd0;
            s_data_q   <= 8'd0;
            enc_addr_q <= '0;
            dec_addr_q <= '0;
            dec_data_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            k_q        <= k_d;
            s_addr_q   <= s_addr_d;
            s_data_q   <= s_data_d;
            enc_addr_q <= enc_addr_d;
            dec_addr_q <= dec_addr_d;
            dec_data_q <= dec_data_d;
        end
    end

    assign bus.s_mem_address   = s_addr_q;
    assign bus.s_mem_data      = s_data_q;
    assign bus.s_mem_wren      = (state_q == ST_SWAP_I_WR) || (state_q == ST_SWAP_J_WR);
    assign bus.enc_rom_address = enc_addr_q;
    assign bus.dec_ram_address = dec_addr_q;
    assign bus.dec_ram_data    = dec_data_q;
    assign bus.dec_ram_wren    = (state_q == ST_DEC_WR);
    assign bus.flag_busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.flag_done       = (state_q == ST_DONE);
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: a 4-byte instance (A) and a 32-byte instance (B)
// with memory models, checked against a plain RC4 model of every write.
module tb_rc4_prga_decrypt;
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic inclk = 1'b0;
    logic reset;
    logic load_a, load_b;
    always #5 inclk = ~inclk;

    rc4_prga_decrypt_if #(.MSG_AW(5)) ba ();
    rc4_prga_decrypt_if #(.MSG_AW(5)) bb ();

    rc4_prga_decrypt #(.MSG_LEN(4),  .MSG_AW(5)) dut_a (.inclk(inclk), .reset(reset), .bus(ba));
    rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(5)) dut_b (.inclk(inclk), .reset(reset), .bus(bb));

    logic [7:0] s_init [256];
    logic [7:0] rom_init [32];
    logic [7:0] s_a [256];
    logic [7:0] rom_a [32];
    logic [7:0] ram_a [32];
    logic [7:0] s_b [256];
    logic [7:0] rom_b [32];
    logic [7:0] ram_b [32];

    wr_t exp_s_a [$];
    wr_t exp_d_a [$];
    wr_t exp_s_b [$];
    wr_t exp_d_b [$];

    int nvec = 0;
    int nfail = 0;

    // Synchronous memories behind instance A (one-cycle q after the address register).
    always @(posedge inclk) begin
        if (load_a) begin
            s_a   <= s_init;
            rom_a <= rom_init;
            ram_a <= '{default: 8'h00};
        end else begin
            if (ba.s_mem_wren)   s_a[ba.s_mem_address]     <= ba.s_mem_data;
            if (ba.dec_ram_wren) ram_a[ba.dec_ram_address] <= ba.dec_ram_data;
        end
        ba.s_mem_q   <= s_a[ba.s_mem_address];
        ba.enc_rom_q <= rom_a[ba.enc_rom_address];
    end

    // Synchronous memories behind instance B.
    always @(posedge inclk) begin
        if (load_b) begin
            s_b   <= s_init;
            rom_b <= rom_init;
            ram_b <= '{default: 8'h00};
        end else begin
            if (bb.s_mem_wren)   s_b[bb.s_mem_address]     <= bb.s_mem_data;
            if (bb.dec_ram_wren) ram_b[bb.dec_ram_address] <= bb.dec_ram_data;
        end
        bb.s_mem_q   <= s_b[bb.s_mem_address];
        bb.enc_rom_q <= rom_b[bb.enc_rom_address];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(input bit sel);
        if (sel)
            return 64'({bb.s_mem_address, bb.s_mem_data, bb.s_mem_wren, bb.enc_rom_address,
                        bb.dec_ram_address, bb.dec_ram_data, bb.dec_ram_wren,
                        bb.flag_busy, bb.flag_done});
        else
            return 64'({ba.s_mem_address, ba.s_mem_data, ba.s_mem_wren, ba.enc_rom_address,
                        ba.dec_ram_address, ba.dec_ram_data, ba.dec_ram_wren,
                        ba.flag_busy, ba.flag_done});
    endfunction

    // mode 0: identity S, mode 1: every S byte 80.
    task automatic load(input bit sel, input int mode, input logic [7:0] romv);
        for (int x = 0; x < 256; x++) s_init[x] = (mode == 0) ? 8'(x) : 8'h80;
        for (int x = 0; x < 32; x++) rom_init[x] = romv;
        @(negedge inclk);
        if (sel) load_b = 1'b1; else load_a = 1'b1;
        @(negedge inclk);
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    // Textbook RC4 PRGA over the preload image; records every expected write in order.
    task automatic model_run(input bit sel, input int len);
        logic [7:0] s [256];
        logic [7:0] i, j, si, sj, t;
        for (int x = 0; x < 256; x++) s[x] = s_init[x];
        if (sel) begin exp_s_b.delete(); exp_d_b.delete(); end
        else     begin exp_s_a.delete(); exp_d_a.delete(); end
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < len; k++) begin
            i = i + 8'd1;
            si = s[i];
            j = j + si;
            sj = s[j];
            s[i] = sj;
            s[j] = si;
            t = si + sj;
            if (sel) begin
                exp_s_b.push_back({i, sj});
                exp_s_b.push_back({j, si});
                exp_d_b.push_back({8'(k), s[t] ^ rom_init[k]});
            end else begin
                exp_s_a.push_back({i, sj});
                exp_s_a.push_back({j, si});
                exp_d_a.push_back({8'(k), s[t] ^ rom_init[k]});
            end
        end
    endtask

    // Compares every S and RAM write of one instance against the model, in order.
    task automatic mon(input bit sel);
        logic sw, dw;
        logic [7:0] sa, sd, da, dd;
        wr_t e;
        int n;
        forever begin
            @(negedge inclk);
            sw = sel ? bb.s_mem_wren : ba.s_mem_wren;
            dw = sel ? bb.dec_ram_wren : ba.dec_ram_wren;
            sa = sel ? bb.s_mem_address : ba.s_mem_address;
            sd = sel ? bb.s_mem_data : ba.s_mem_data;
            da = sel ? {3'b000, bb.dec_ram_address} : {3'b000, ba.dec_ram_address};
            dd = sel ? bb.dec_ram_data : ba.dec_ram_data;
            if (sw || dw) chk("wren_exclusive", 64'(sw & dw), 64'd0);
            if (sw) begin
                n = sel ? exp_s_b.size() : exp_s_a.size();
                if (n == 0) begin
                    nvec++; nfail++;
                    $display("FAIL s_write: got unexpected addr %h data %h, required no write", sa, sd);
                end else begin
                    if (sel) e = exp_s_b.pop_front(); else e = exp_s_a.pop_front();
                    chk(sel ? "b_s_write" : "a_s_write", 64'({sa, sd}), 64'(e));
                end
            end
            if (dw) begin
                n = sel ? exp_d_b.size() : exp_d_a.size();
                if (n == 0) begin
                    nvec++; nfail++;
                    $display("FAIL ram_write: got unexpected addr %h data %h, required no write", da, dd);
                end else begin
                    if (sel) e = exp_d_b.pop_front(); else e = exp_d_a.pop_front();
                    chk(sel ? "b_ram_write" : "a_ram_write", 64'({da, dd}), 64'(e));
                end
            end
        end
    endtask

    task automatic go(input bit sel, output int cyc, output bit busy_ok, output int ns, output int nd);
        logic dn;
        cyc = 0; busy_ok = 1'b1; ns = 0; nd = 0; dn = 1'b0;
        @(negedge inclk);
        if (sel) bb.flag_start = 1'b1; else ba.flag_start = 1'b1;
        while (!dn && cyc < 700) begin
            @(posedge inclk);
            #1;
            cyc++;
            dn = sel ? bb.flag_done : ba.flag_done;
            if (!dn) begin
                if (!(sel ? bb.flag_busy : ba.flag_busy)) busy_ok = 1'b0;
                ns += int'(sel ? bb.s_mem_wren : ba.s_mem_wren);
                nd += int'(sel ? bb.dec_ram_wren : ba.dec_ram_wren);
            end
        end
        chk("done_within_budget", 64'(dn), 64'd1);
    endtask

    task automatic drop(input bit sel);
        @(negedge inclk);
        if (sel) bb.flag_start = 1'b0; else ba.flag_start = 1'b0;
        @(posedge inclk);
        #1;
    endtask

    initial begin
        int cyc, ns, nd, bad;
        bit bok;
        reset = 1'b1;
        load_a = 1'b0;
        load_b = 1'b0;
        ba.flag_start = 1'b0;
        bb.flag_start = 1'b0;
        fork
            mon(1'b0);
            mon(1'b1);
        join_none
        repeat (3) @(posedge inclk);
        #1;
        chk("reset_outs_a", outs(1'b0), 64'd0);
        chk("reset_outs_b", outs(1'b1), 64'd0);
        @(negedge inclk);
        reset = 1'b0;

        // Identity S, ROM 00, four bytes.
        load(1'b0, 0, 8'h00);
        model_run(1'b0, 4);
        chk("model_pin_keystream", 64'({exp_d_a[0].d, exp_d_a[1].d, exp_d_a[2].d, exp_d_a[3].d}), 64'h0205070D);
        go(1'b0, cyc, bok, ns, nd);
        chk("a_latency", 64'(cyc), 64'd75);
        chk("a_busy_throughout", 64'(bok), 64'd1);
        chk("a_wren_counts", 64'({ns[15:0], nd[15:0]}), 64'h0008_0004);
        chk("t1_ram", 64'({ram_a[0], ram_a[1], ram_a[2], ram_a[3]}), 64'h0205070D);
        chk("t1_s_after", 64'({s_a[2], s_a[3], s_a[4], s_a[5], s_a[9]}), 64'h0305090204);
        chk("a_writes_drained", 64'(exp_s_a.size() + exp_d_a.size()), 64'd0);
        drop(1'b0);

        // Identity S, ROM FF: keystream inverted.
        load(1'b0, 0, 8'hFF);
        model_run(1'b0, 4);
        go(1'b0, cyc, bok, ns, nd);
        chk("t2_ram", 64'({ram_a[0], ram_a[1], ram_a[2], ram_a[3]}), 64'hFDFAF8F2);

        // Start held through DONE: no second run.
        repeat (30) @(posedge inclk);
        #1;
        chk("done_held", 64'({ba.flag_busy, ba.flag_done}), 64'd1);
        drop(1'b0);
        chk("idle_after_drop", 64'({ba.flag_busy, ba.flag_done}), 64'd0);
        load(1'b0, 0, 8'h55);
        model_run(1'b0, 4);
        go(1'b0, cyc, bok, ns, nd);
        chk("rerun_latency", 64'(cyc), 64'd75);
        chk("rerun_ram", 64'({ram_a[0], ram_a[1], ram_a[2], ram_a[3]}), 64'h57505258);
        drop(1'b0);

        // S all 80, 32 bytes: latency, pulse counts, j wraps and S is unchanged.
        load(1'b1, 1, 8'h00);
        model_run(1'b1, 32);
        go(1'b1, cyc, bok, ns, nd);
        chk("b_latency", 64'(cyc), 64'd579);
        chk("b_busy_throughout", 64'(bok), 64'd1);
        chk("b_s_wren_pulses", 64'(ns), 64'd64);
        chk("b_ram_wren_pulses", 64'(nd), 64'd32);
        bad = 0;
        for (int x = 0; x < 32; x++) if (ram_b[x] !== 8'h80) bad++;
        chk("t3_ram_all_80", 64'(bad), 64'd0);
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_b[x] !== 8'h80) bad++;
        chk("t3_s_unchanged", 64'(bad), 64'd0);
        chk("b_writes_drained", 64'(exp_s_b.size() + exp_d_b.size()), 64'd0);
        drop(1'b1);

        // Reset at cycle 100 of a run, then a clean rerun.
        load(1'b1, 0, 8'h00);
        model_run(1'b1, 32);
        @(negedge inclk);
        bb.flag_start = 1'b1;
        repeat (100) @(posedge inclk);
        #1;
        chk("b_busy_mid_run", 64'(bb.flag_busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrun_reset_outs", outs(1'b1), 64'd0);
        bb.flag_start = 1'b0;
        @(negedge inclk);
        reset = 1'b0;
        load(1'b1, 0, 8'h00);
        model_run(1'b1, 32);
        go(1'b1, cyc, bok, ns, nd);
        chk("t5_latency", 64'(cyc), 64'd579);
        chk("t5_ram", 64'({ram_b[0], ram_b[1], ram_b[2], ram_b[3]}), 64'h0205070D);
        chk("t5_writes_drained", 64'(exp_s_b.size() + exp_d_b.size()), 64'd0);
        drop(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
